pipelined_decode_stage: RTL
===========================

PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

Interface
REQ-001 Parameter BIT_DEPTH, default 32: SHALL set the datapath width of register data, RegWriteData, RD1, RD2 and ImmOut.
REQ-002 Parameter LOG_PORT_DEPTH, default 5: SHALL set the register-address width; the register file SHALL hold 2**LOG_PORT_DEPTH entries.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  Instruction is valid; in_ready  out  1  stage accepts Instruction this cycle.
REQ-007 Instruction  in  32  MIPS instruction word.
REQ-008 RegWriteEn  in  1, RegWriteAddr  in  LOG_PORT_DEPTH, RegWriteData  in  BIT_DEPTH: writeback port.
REQ-009 flush  in  1  discard the held entry.
REQ-010 out_valid  out  1, out_ready  in  1: ID/EX register handshake.
REQ-011 RegWrite, MemToReg, MemWrite, ALUSrc  out  1 each; ALUControl  out  4: registered control.
REQ-012 RD1, RD2, ImmOut  out  BIT_DEPTH; WriteReg  out  LOG_PORT_DEPTH (RegDst ? rd : rt); RsOut, RtOut  out  LOG_PORT_DEPTH.

Function
REQ-013 Register file SHALL provide two combinational reads (rs = Instruction[25:21], rt = Instruction[20:16], truncated or zero-extended to LOG_PORT_DEPTH) and one write on the clk edge when RegWriteEn=1.
REQ-014 Register 0 SHALL read as 0; writes to address 0 SHALL be ignored.
REQ-015 Control SHALL be decoded from Opcode [31:26] and Funct [5:0] using the team ControlUnit encoding.
REQ-016 ImmOut SHALL be Instruction[15:0] sign-extended to BIT_DEPTH.
REQ-017 Transfer-in occurs when in_valid && in_ready; all outputs SHALL present the decoded values one cycle later, with out_valid=1 (latency 1).
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-019 hazard SHALL be asserted when out_valid && MemToReg && RegWrite && WriteReg != 0 && (WriteReg == rs || WriteReg == rt) for the current Instruction.
REQ-020 On hazard with out_ready=1, the held entry SHALL leave, and out_valid SHALL be 0 next cycle (one bubble); the upstream instruction SHALL be held by in_ready=0.
REQ-021 On hazard with out_ready=0, the held entry SHALL stay unchanged.
REQ-022 When out_valid && !out_ready && !flush, all outputs SHALL hold their values.
REQ-023 When out_ready=1 and there is no transfer-in, out_valid SHALL fall to 0 next cycle.
REQ-024 flush SHALL force out_valid=0 next cycle and SHALL block transfer-in that cycle, regardless of in_valid, out_ready or hazard.
REQ-025 When out_valid=0, payload outputs are don't-care, but they SHALL NOT change except on transfer-in or reset.

Reset
REQ-026 With rst=1 at a clk edge, out_valid and all payload outputs SHALL become 0 and all register-file entries SHALL be cleared.
REQ-027 rst SHALL take priority over flush, over writeback and over transfer-in.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro DECODE_WB_BYPASS_EN defined: when RegWriteEn && RegWriteAddr != 0 && RegWriteAddr matches rs or rt, RD1 or RD2 SHALL capture RegWriteData in the same cycle.
REQ-030 Macro DECODE_WB_BYPASS_EN undefined: RD1 and RD2 SHALL capture the pre-write register contents; there SHALL be no bypass.

Verification
REQ-031 Reset: write r5=0x1234, assert rst 1 cycle, then issue add r1,r5,r0 -> RD1=0 and out_valid=0 in the cycle after reset.
REQ-032 Basic decode: r2=7, r3=9, issue add r4,r2,r3 with out_ready=1 -> next cycle out_valid=1, RD1=7, RD2=9, WriteReg=4, RegWrite=1, ALUSrc=0.
REQ-033 Load-use: lw r8,4(r0) then add r9,r8,r1 -> in_ready=0 for exactly 1 cycle, one out_valid=0 bubble, then add is emitted with RsOut=8; ImmOut for lw = 4, for lw r8,-4(r0) = 0xFFFFFFFC.
REQ-034 Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0; flush=1 with in_valid=1 -> out_valid=0 next cycle and the instruction is not accepted.
REQ-035 Same-cycle write/read: RegWriteEn=1, RegWriteAddr=6, RegWriteData=0xAA while decoding an instruction with rs=6 (old value 0x11) -> RD1=0xAA with DECODE_WB_BYPASS_EN, RD1=0x11 without it.
REQ-036 r0 write: write 0xFF to r0, then read r0 -> 0.

Source files
------------

// File: rtl/pipelined_decode_stage_if.sv
// Handshake, writeback and ID/EX payload bundle for pipelined_decode_stage.
// The master side drives instructions and writeback; the slave side is the decode stage.
interface pipelined_decode_stage_if #(
  parameter int BIT_DEPTH      = 32,
  parameter int LOG_PORT_DEPTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               Instruction;
  logic                      RegWriteEn;
  logic [LOG_PORT_DEPTH-1:0] RegWriteAddr;
  logic [BIT_DEPTH-1:0]      RegWriteData;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic                      RegWrite;
  logic                      MemToReg;
  logic                      MemWrite;
  logic                      ALUSrc;
  logic [3:0]                ALUControl;
  logic [BIT_DEPTH-1:0]      RD1;
  logic [BIT_DEPTH-1:0]      RD2;
  logic [BIT_DEPTH-1:0]      ImmOut;
  logic [LOG_PORT_DEPTH-1:0] WriteReg;
  logic [LOG_PORT_DEPTH-1:0] RsOut;
  logic [LOG_PORT_DEPTH-1:0] RtOut;

  modport master (
    output in_valid, Instruction, RegWriteEn, RegWriteAddr, RegWriteData, flush, out_ready,
    input  in_ready, out_valid, RegWrite, MemToReg, MemWrite, ALUSrc, ALUControl,
    input  RD1, RD2, ImmOut, WriteReg, RsOut, RtOut
  );

  modport slave (
    input  in_valid, Instruction, RegWriteEn, RegWriteAddr, RegWriteData, flush, out_ready,
    output in_ready, out_valid, RegWrite, MemToReg, MemWrite, ALUSrc, ALUControl,
    output RD1, RD2, ImmOut, WriteReg, RsOut, RtOut
  );
endinterface

// File: rtl/pipelined_decode_stage.sv
// MIPS decode stage: 2R/1W register file, control decode, load-use stall and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into RD1/RD2.
module pipelined_decode_stage #(
  parameter int BIT_DEPTH      = 32,
  parameter int LOG_PORT_DEPTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_decode_stage_if.slave bus
);
  localparam int NUM_REGS = 2 ** LOG_PORT_DEPTH;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_control;
  } ctrl_t;

  // Unknown opcodes/functs decode to a harmless no-write, no-store bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = ctrl_t'(9'd0);
    case (opcode)
      6'h00: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          6'h20:   c.alu_control = 4'b0010;
          6'h22:   c.alu_control = 4'b0110;
          6'h24:   c.alu_control = 4'b0000;
          6'h25:   c.alu_control = 4'b0001;
          6'h27:   c.alu_control = 4'b1100;
          6'h2A:   c.alu_control = 4'b0111;
          default: c.reg_write   = 1'b0;
        endcase
      end
      6'h23: begin
        c.reg_write   = 1'b1;
        c.mem_to_reg  = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0010;
      end
      6'h2B: begin
        c.mem_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0010;
      end
      6'h04: c.alu_control = 4'b0110;
      6'h08: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0010;
      end
      6'h0A: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0111;
      end
      6'h0C: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0000;
      end
      6'h0D: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = 4'b0001;
      end
      default: c = ctrl_t'(9'd0);
    endcase
    return c;
  endfunction

  logic [BIT_DEPTH-1:0]      r_regs [NUM_REGS];
  logic [LOG_PORT_DEPTH-1:0] w_rs;
  logic [LOG_PORT_DEPTH-1:0] w_rt;
  logic [LOG_PORT_DEPTH-1:0] w_rd;
  logic [BIT_DEPTH-1:0]      w_rd1;
  logic [BIT_DEPTH-1:0]      w_rd2;
  logic [BIT_DEPTH-1:0]      w_imm;
  ctrl_t                     w_ctrl;
  logic                      w_wb_active;
  logic                      w_hazard;
  logic                      w_in_ready;
  logic                      w_xfer;
  logic                      w_unused_shamt;

  logic                      r_out_valid;
  logic                      r_reg_write;
  logic                      r_mem_to_reg;
  logic                      r_mem_write;
  logic                      r_alu_src;
  logic [3:0]                r_alu_control;
  logic [BIT_DEPTH-1:0]      r_rd1;
  logic [BIT_DEPTH-1:0]      r_rd2;
  logic [BIT_DEPTH-1:0]      r_imm;
  logic [LOG_PORT_DEPTH-1:0] r_write_reg;
  logic [LOG_PORT_DEPTH-1:0] r_rs_out;
  logic [LOG_PORT_DEPTH-1:0] r_rt_out;

  assign w_rs           = LOG_PORT_DEPTH'(bus.Instruction[25:21]);
  assign w_rt           = LOG_PORT_DEPTH'(bus.Instruction[20:16]);
  assign w_rd           = LOG_PORT_DEPTH'(bus.Instruction[15:11]);
  assign w_imm          = {{(BIT_DEPTH-16){bus.Instruction[15]}}, bus.Instruction[15:0]};
  assign w_ctrl         = decode_ctrl(bus.Instruction[31:26], bus.Instruction[5:0]);
  assign w_unused_shamt = ^bus.Instruction[10:6];
  assign w_wb_active    = bus.RegWriteEn && (bus.RegWriteAddr != {LOG_PORT_DEPTH{1'b0}});

  // Load-use: the held load targets a source of the instruction now being presented.
  assign w_hazard   = r_out_valid && r_mem_to_reg && r_reg_write &&
                      (r_write_reg != {LOG_PORT_DEPTH{1'b0}}) &&
                      ((r_write_reg == w_rs) || (r_write_reg == w_rt));
  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_xfer     = bus.in_valid && w_in_ready;

  // Register-file read ports with r0 hard-wired to zero
  always_comb begin
    w_rd1 = {BIT_DEPTH{1'b0}};
    w_rd2 = {BIT_DEPTH{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
    if (w_wb_active && (bus.RegWriteAddr == w_rs)) begin
      w_rd1 = bus.RegWriteData;
    end else if (w_rs != {LOG_PORT_DEPTH{1'b0}}) begin
      w_rd1 = r_regs[w_rs];
    end else begin
      w_rd1 = {BIT_DEPTH{1'b0}};
    end
    if (w_wb_active && (bus.RegWriteAddr == w_rt)) begin
      w_rd2 = bus.RegWriteData;
    end else if (w_rt != {LOG_PORT_DEPTH{1'b0}}) begin
      w_rd2 = r_regs[w_rt];
    end else begin
      w_rd2 = {BIT_DEPTH{1'b0}};
    end
`else
    if (w_rs != {LOG_PORT_DEPTH{1'b0}}) begin
      w_rd1 = r_regs[w_rs];
    end else begin
      w_rd1 = {BIT_DEPTH{1'b0}};
    end
    if (w_rt != {LOG_PORT_DEPTH{1'b0}}) begin
      w_rd2 = r_regs[w_rt];
    end else begin
      w_rd2 = {BIT_DEPTH{1'b0}};
    end
`endif
  end

  // Register-file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {BIT_DEPTH{1'b0}};
      end
    end else if (w_wb_active) begin
      r_regs[bus.RegWriteAddr] <= bus.RegWriteData;
    end
  end

  // ID/EX register: payload only moves on transfer-in, valid drops on drain or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 4'b0000;
      r_rd1         <= {BIT_DEPTH{1'b0}};
      r_rd2         <= {BIT_DEPTH{1'b0}};
      r_imm         <= {BIT_DEPTH{1'b0}};
      r_write_reg   <= {LOG_PORT_DEPTH{1'b0}};
      r_rs_out      <= {LOG_PORT_DEPTH{1'b0}};
      r_rt_out      <= {LOG_PORT_DEPTH{1'b0}};
    end else if (w_xfer) begin
      r_out_valid   <= 1'b1;
      r_reg_write   <= w_ctrl.reg_write;
      r_mem_to_reg  <= w_ctrl.mem_to_reg;
      r_mem_write   <= w_ctrl.mem_write;
      r_alu_src     <= w_ctrl.alu_src;
      r_alu_control <= w_ctrl.alu_control;
      r_rd1         <= w_rd1;
      r_rd2         <= w_rd2;
      r_imm         <= w_imm;
      r_write_reg   <= w_ctrl.reg_dst ? w_rd : w_rt;
      r_rs_out      <= w_rs;
      r_rt_out      <= w_rt;
    end else if (bus.flush || bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.RegWrite   = r_reg_write;
  assign bus.MemToReg   = r_mem_to_reg;
  assign bus.MemWrite   = r_mem_write;
  assign bus.ALUSrc     = r_alu_src;
  assign bus.ALUControl = r_alu_control;
  assign bus.RD1        = r_rd1;
  assign bus.RD2        = r_rd2;
  assign bus.ImmOut     = r_imm;
  assign bus.WriteReg   = r_write_reg;
  assign bus.RsOut      = r_rs_out;
  assign bus.RtOut      = r_rt_out;
endmodule
